// File: rtl/coin_casher_if.sv
// Coin-mech / game-controller signal bundle for the coin acceptor.
// The master side drives the coin-mech inputs; the slave side is the acceptor.
interface coin_casher_if;
  logic       return_coin;
  logic       timer_finish;
  logic       coin_insert;
  logic       game_finish;
  logic [2:0] inserted_coin;
  logic       timer_en;
  logic       coin_reject;
  logic       eat_coins;
  logic       reset_timer;
  logic       spit_coin;
  logic       wait_ready;
  logic       game_start;

  modport master (
    output return_coin, timer_finish, coin_insert, game_finish, inserted_coin,
    input  timer_en, coin_reject, eat_coins, reset_timer, spit_coin, wait_ready, game_start
  );

  modport slave (
    input  return_coin, timer_finish, coin_insert, game_finish, inserted_coin,
    output timer_en, coin_reject, eat_coins, reset_timer, spit_coin, wait_ready, game_start
  );
endinterface

// File: rtl/coin_casher.sv
// Coin acceptor FSM: validates coins, counts credit, starts the game or refunds.
// One-hot state register with Moore outputs; the credit timer lives outside.
module coin_casher #(
  parameter int         COINS_PER_GAME = 3,
  parameter logic [2:0] VALID_COIN     = 3'b100
) (
  input logic          clk,
  input logic          rst_n,
  coin_casher_if.slave bus
);
  localparam int            CW       = (COINS_PER_GAME > 1) ? $clog2(COINS_PER_GAME) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COINS_PER_GAME - 1);

  typedef enum logic [11:0] {
    WAIT_START  = 12'h001,
    CHECK_COIN  = 12'h002,
    SPIT_ALL    = 12'h004,
    CHECK_NUM   = 12'h008,
    REJECT      = 12'h010,
    START_GAME  = 12'h020,
    GAME_END    = 12'h040,
    WAIT_FIN    = 12'h080,
    START_TIMER = 12'h100,
    INCR_COUNT  = 12'h200,
    INIT        = 12'h400
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] coin_cnt;
  logic [2:0]    coin_reg;
  logic          refund_req;

  assign refund_req = bus.return_coin | bus.timer_finish;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= INIT;
      coin_cnt <= '0;
      coin_reg <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        WAIT_START: if (!refund_req && bus.coin_insert) coin_reg <= bus.inserted_coin;
        INCR_COUNT: coin_cnt <= coin_cnt + 1'b1;
        START_GAME, SPIT_ALL: coin_cnt <= '0;
        default: ;
      endcase
    end
  end

  logic timer_en, coin_reject, eat_coins, reset_timer, spit_coin, wait_ready, game_start;

  always_comb begin
    state_d     = state_q;
    timer_en    = 1'b0;
    coin_reject = 1'b0;
    eat_coins   = 1'b0;
    reset_timer = 1'b0;
    spit_coin   = 1'b0;
    wait_ready  = 1'b0;
    game_start  = 1'b0;
    case (state_q)
      INIT:       state_d = WAIT_START;
      WAIT_START: begin
        wait_ready = 1'b1;
        // refund outranks a coin arriving in the same cycle
        if (refund_req)           state_d = SPIT_ALL;
        else if (bus.coin_insert) state_d = CHECK_COIN;
      end
      CHECK_COIN: state_d = (coin_reg == VALID_COIN) ? CHECK_NUM : REJECT;
      REJECT: begin
        coin_reject = 1'b1;
        state_d     = WAIT_START;
      end
      CHECK_NUM: begin
        if (coin_cnt == CNT_LAST)  state_d = START_GAME;
        else if (coin_cnt == '0)   state_d = START_TIMER;
        else                       state_d = INCR_COUNT;
      end
      START_TIMER: begin
        timer_en = 1'b1;
        state_d  = INCR_COUNT;
      end
      INCR_COUNT: state_d = WAIT_START;
      START_GAME: begin
        game_start  = 1'b1;
        eat_coins   = 1'b1;
        reset_timer = 1'b1;
        coin_reject = 1'b1;
        state_d     = WAIT_FIN;
      end
      WAIT_FIN: begin
        // mech keeps rejecting coins while a game runs
        coin_reject = 1'b1;
        if (bus.game_finish) state_d = GAME_END;
      end
      GAME_END: state_d = WAIT_START;
      SPIT_ALL: begin
        spit_coin   = 1'b1;
        reset_timer = 1'b1;
        state_d     = WAIT_START;
      end
      default: state_d = INIT;
    endcase
  end

  assign bus.timer_en    = timer_en;
  assign bus.coin_reject = coin_reject;
  assign bus.eat_coins   = eat_coins;
  assign bus.reset_timer = reset_timer;
  assign bus.spit_coin   = spit_coin;
  assign bus.wait_ready  = wait_ready;
  assign bus.game_start  = game_start;
endmodule

// File: tb/tb_coin_casher.sv
// Bench for coin_casher: directed scenarios plus a random action stream,
// each checked cycle by cycle against a transaction-level credit model.
module tb_coin_casher;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coin_casher_if bus();
  coin_casher #(.COINS_PER_GAME(N), .VALID_COIN(3'b100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // {timer_en, coin_reject, eat_coins, reset_timer, spit_coin, wait_ready, game_start}
  logic [6:0] obs;
  assign obs = {bus.timer_en, bus.coin_reject, bus.eat_coins, bus.reset_timer,
                bus.spit_coin, bus.wait_ready, bus.game_start};

  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_WAIT  = 7'b0000010;
  localparam logic [6:0] O_TIMER = 7'b1000000;
  localparam logic [6:0] O_REJ   = 7'b0100000;
  localparam logic [6:0] O_START = 7'b0111001;
  localparam logic [6:0] O_SPIT  = 7'b0001100;
  localparam logic [6:0] O_FIN   = 7'b0100000;

  localparam int K_IDLE = 0, K_RET = 1, K_TMR = 2, K_COIN = 3, K_BOTH = 4, K_FIN = 5;

  int checks = 0;
  int errors = 0;

  // credit model: held coin count and whether a game is running
  int         m_cnt = 0;
  bit         m_fin = 0;
  logic [6:0] exp_q[$];

  function automatic void build_exp(input int k, input logic [2:0] code);
    exp_q.delete();
    if (m_fin) begin
      if (k == K_FIN) begin
        exp_q = '{O_IDLE, O_WAIT};
        m_fin = 0;
      end else exp_q = '{O_FIN};
    end else if (k == K_RET || k == K_TMR || k == K_BOTH) begin
      exp_q = '{O_SPIT, O_WAIT};
      m_cnt = 0;
    end else if (k == K_COIN) begin
      if (code != 3'b100) exp_q = '{O_IDLE, O_REJ, O_WAIT};
      else if (m_cnt == N - 1) begin
        exp_q = '{O_IDLE, O_IDLE, O_START, O_FIN};
        m_cnt = 0;
        m_fin = 1;
      end else if (m_cnt == 0) begin
        exp_q = '{O_IDLE, O_IDLE, O_TIMER, O_IDLE, O_WAIT};
        m_cnt = 1;
      end else begin
        exp_q = '{O_IDLE, O_IDLE, O_IDLE, O_WAIT};
        m_cnt = m_cnt + 1;
      end
    end else exp_q = '{O_WAIT};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // apply one action for a single edge, then release the inputs
  task automatic step(input int k, input logic [2:0] code);
    build_exp(k, code);
    bus.return_coin   = (k == K_RET || k == K_BOTH);
    bus.timer_finish  = (k == K_TMR);
    bus.coin_insert   = (k == K_COIN || k == K_BOTH);
    bus.game_finish   = (k == K_FIN);
    bus.inserted_coin = code;
    tick();
    bus.return_coin   = 1'b0;
    bus.timer_finish  = 1'b0;
    bus.coin_insert   = 1'b0;
    bus.game_finish   = 1'b0;
    bus.inserted_coin = 3'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("FAIL reset_outs obs=%b exp=%b", obs, O_IDLE); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== O_WAIT) begin errors++; $display("FAIL reset_to_wait obs=%b exp=%b", obs, O_WAIT); end
    m_cnt = 0;
    m_fin = 0;
    for (int j = 0; j < 3; j++) begin
      step(K_IDLE, 3'b000);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        checks++;
        if (obs !== exp_q[i]) begin errors++; $display("FAIL reset_hold s%0d c%0d obs=%b exp=%b", j, i, obs, exp_q[i]); end
      end
    end
  endtask

  task automatic test_return();
    int ks[3] = '{K_RET, K_IDLE, K_FIN};
    for (int j = 0; j < 3; j++) begin
      step(ks[j], 3'b100);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        checks++;
        if (obs !== exp_q[i]) begin errors++; $display("FAIL return s%0d c%0d obs=%b exp=%b", j, i, obs, exp_q[i]); end
      end
    end
  endtask

  task automatic test_reject();
    logic [2:0] cs[3] = '{3'b001, 3'b011, 3'b111};
    for (int j = 0; j < 3; j++) begin
      step(K_COIN, cs[j]);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        checks++;
        if (obs !== exp_q[i]) begin errors++; $display("FAIL reject s%0d c%0d obs=%b exp=%b", j, i, obs, exp_q[i]); end
      end
    end
  endtask

  task automatic test_game();
    int ks[10] = '{K_COIN, K_IDLE, K_COIN, K_IDLE, K_COIN, K_RET, K_COIN, K_TMR, K_FIN, K_IDLE};
    for (int j = 0; j < 10; j++) begin
      step(ks[j], 3'b100);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        checks++;
        if (obs !== exp_q[i]) begin errors++; $display("FAIL game s%0d c%0d obs=%b exp=%b", j, i, obs, exp_q[i]); end
      end
    end
  endtask

  task automatic test_timeout();
    int ks[5] = '{K_COIN, K_IDLE, K_TMR, K_COIN, K_RET};
    for (int j = 0; j < 5; j++) begin
      step(ks[j], 3'b100);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        checks++;
        if (obs !== exp_q[i]) begin errors++; $display("FAIL timeout s%0d c%0d obs=%b exp=%b", j, i, obs, exp_q[i]); end
      end
    end
  endtask

  task automatic test_both_and_reset();
    int ks[6] = '{K_BOTH, K_COIN, K_COIN, K_COIN, K_BOTH, K_COIN};
    for (int j = 0; j < 6; j++) begin
      step(ks[j], 3'b100);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        checks++;
        if (obs !== exp_q[i]) begin errors++; $display("FAIL both s%0d c%0d obs=%b exp=%b", j, i, obs, exp_q[i]); end
      end
    end
    // model is now in a running game with the last coin ignored; abort it by reset
    for (int r = 0; r < 2; r++) begin
      rst_n = 1'b0;
      tick();
      checks++;
      if (obs !== O_IDLE) begin errors++; $display("FAIL rst_abort r%0d obs=%b exp=%b", r, obs, O_IDLE); end
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs !== O_WAIT) begin errors++; $display("FAIL rst_resume r%0d obs=%b exp=%b", r, obs, O_WAIT); end
      m_cnt = 0;
      m_fin = 0;
      step(K_COIN, 3'b100);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        checks++;
        if (obs !== exp_q[i]) begin errors++; $display("FAIL rst_coin r%0d c%0d obs=%b exp=%b", r, i, obs, exp_q[i]); end
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 80; j++) begin
      int         k;
      logic [2:0] code;
      int         r = $urandom_range(0, 99);
      if (m_fin && r < 30)  k = K_FIN;
      else if (r < 60)      k = K_COIN;
      else if (r < 70)      k = K_RET;
      else if (r < 78)      k = K_TMR;
      else if (r < 83)      k = K_BOTH;
      else                  k = K_IDLE;
      code = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 7));
      step(k, code);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        checks++;
        if (obs !== exp_q[i]) begin errors++; $display("FAIL random s%0d k%0d code%b c%0d obs=%b exp=%b", j, k, code, i, obs, exp_q[i]); end
      end
    end
  endtask

  initial begin
    bus.return_coin   = 1'b0;
    bus.timer_finish  = 1'b0;
    bus.coin_insert   = 1'b0;
    bus.game_finish   = 1'b0;
    bus.inserted_coin = 3'b000;
    test_reset();
    test_return();
    test_reject();
    test_game();
    test_timeout();
    test_both_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
